// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide controller with fixed-latency busy window.
// Ports: clk, reset (sync, active-high); start, md_op, src_a, src_b, d_md_use in;
//        busy, stall, hi, lo out. Results are staged in a shadow pair and
//        committed to hi/lo on the final busy cycle.
module muldiv_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] sh_hi_q;
    logic [31:0] sh_lo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] sh_hi_d;
    logic [31:0] sh_lo_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [31:0]        quo_s;
    logic [31:0]        rem_s;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic               md_start;
    logic               div_zero;

    assign a_s = src_a;
    assign b_s = src_b;

    // Low 64 bits of the product of sign-extended operands is the signed product.
    assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    assign prod_u = {32'b0, src_a} * {32'b0, src_b};

    // Signed / and % truncate toward zero; remainder takes the dividend sign.
    assign quo_s = a_s / b_s;
    assign rem_s = a_s % b_s;
    assign quo_u = src_a / src_b;
    assign rem_u = src_a % src_b;

    assign div_zero = (src_b == 32'd0);

    // Only mult/multu/div/divu occupy the unit; mthi/mtlo/no-op never stall.
    assign md_start = start & ~md_op[2];

    always_comb begin
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        case (md_op)
            3'b000: {sh_hi_d, sh_lo_d} = prod_s;
            3'b001: {sh_hi_d, sh_lo_d} = prod_u;
            // Divide by zero stages the current hi/lo so completion is a no-op.
            3'b010: {sh_hi_d, sh_lo_d} = div_zero ? {hi_q, lo_q} : {rem_s, quo_s};
            3'b011: {sh_hi_d, sh_lo_d} = div_zero ? {hi_q, lo_q} : {rem_u, quo_u};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sh_hi_q <= 32'd0;
            sh_lo_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            3'b000, 3'b001: cnt_q <= 4'(MUL_CYC);
                            3'b010, 3'b011: cnt_q <= 4'(DIV_CYC);
                            3'b100:         hi_q  <= src_a;
                            3'b101:         lo_q  <= src_a;
                            default: ;
                        endcase
                    end
                    if (md_start) begin
                        state_q <= RUN;
                        sh_hi_q <= sh_hi_d;
                        sh_lo_q <= sh_lo_d;
                    end
                end
                RUN: begin
                    if (cnt_q == 4'd1) begin
                        hi_q    <= sh_hi_q;
                        lo_q    <= sh_lo_q;
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
            endcase
        end
    end

    assign busy  = (state_q == RUN);
    assign stall = d_md_use & (md_start | busy);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
